shuffle_mem: RTL and testbench

SHUFFLE_MEM -- requirements
Module: shuffle_mem

---
 rtl/rc4_pkg.sv | 22 ++
 rtl/key_byte_sel.sv | 25 ++
 rtl/shuffle_mem.sv | 142 ++++++++++++++
 tb/tb_shuffle_mem.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-scheduling block: bus widths, the
// default key length and the controller state encoding.
package rc4_pkg;

  localparam int ADDR_W        = 8;
  localparam int DATA_W        = 8;
  localparam int KEY_BYTES_DEF = 3;

  typedef enum logic [3:0] {
    IDLE,
    RD_I,
    WT_I,
    CAP_I,
    RD_J,
    WT_J,
    CAP_J,
    WR_I,
    WR_J,
    DONE
  } state_e;

endpackage

// File: rtl/key_byte_sel.sv
// Combinational key-byte selector: picks key byte (idx mod KEY_BYTES),
// where byte 0 sits in the most significant position of the key vector.
module key_byte_sel
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEF
) (
  input  logic [ADDR_W-1:0]      idx_i,
  input  logic [8*KEY_BYTES-1:0] key_i,
  output logic [DATA_W-1:0]      key_byte_o
);

  int sel;

  // NOTE: every combinational output gets a default before the loop so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    sel        = int'(idx_i) % KEY_BYTES;
    key_byte_o = '0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (sel == k) key_byte_o = key_i[8*(KEY_BYTES-k)-1 -: 8];
    end
  end

endmodule

// File: rtl/shuffle_mem.sv
// RC4 key-scheduling controller: one swap pass over an external S memory
// with two-cycle read latency. Optional macro SHUFFLE_KEY_LATCH_EN registers
// the key at start; otherwise the live key input is used throughout.
module shuffle_mem
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  output logic [ADDR_W-1:0]      address,
  output logic [DATA_W-1:0]      data,
  output logic                   wen,
  input  logic [DATA_W-1:0]      q,
  output logic                   finished
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   i_q, i_d;
  logic [ADDR_W-1:0]   j_q, j_d;
  logic [DATA_W-1:0]   si_q, si_d;
  logic [DATA_W-1:0]   sj_q, sj_d;
  logic [DATA_W-1:0]   key_byte;
  logic [8*KEY_BYTES-1:0] key_use;
  logic                key_load;

`ifdef SHUFFLE_KEY_LATCH_EN
  logic [8*KEY_BYTES-1:0] key_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         key_q <= '0;
    else if (key_load) key_q <= secret_key;
  end

  assign key_use = key_q;
`else
  assign key_use = secret_key;
`endif

  key_byte_sel #(
    .KEY_BYTES (KEY_BYTES)
  ) u_key_sel (
    .idx_i      (i_q),
    .key_i      (key_use),
    .key_byte_o (key_byte)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
    end
  end

  // Outputs decode from state alone, so an async reset clears them at once.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    si_d     = si_q;
    sj_d     = sj_q;
    address  = '0;
    data     = '0;
    wen      = 1'b0;
    finished = 1'b0;
    key_load = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RD_I;
          i_d      = '0;
          j_d      = '0;
          key_load = 1'b1;
        end
      end
      RD_I: begin
        address = i_q;
        state_d = WT_I;
      end
      WT_I: begin
        address = i_q;
        state_d = CAP_I;
      end
      CAP_I: begin
        address = i_q;
        si_d    = q;
        j_d     = j_q + q + key_byte;
        state_d = RD_J;
      end
      RD_J: begin
        address = j_q;
        state_d = WT_J;
      end
      WT_J: begin
        address = j_q;
        state_d = CAP_J;
      end
      CAP_J: begin
        address = j_q;
        sj_d    = q;
        state_d = WR_I;
      end
      WR_I: begin
        address = i_q;
        data    = sj_q;
        wen     = 1'b1;
        state_d = WR_J;
      end
      WR_J: begin
        address = j_q;
        data    = si_q;
        wen     = 1'b1;
        if (i_q == 8'hFF) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + 8'd1;
          state_d = RD_I;
        end
      end
      DONE: begin
        finished = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shuffle_mem.sv
// Self-checking bench for shuffle_mem: directed write-sequence table, full-pass
// comparison against a software KSA model, start/reset corner cases.
module tb_shuffle_mem;
  import rc4_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] secret_key;
  logic [7:0]  address;
  logic [7:0]  data;
  logic        wen;
  logic [7:0]  q;
  logic        finished;

  logic [7:0]  mem [256];
  logic [7:0]  rd1;
  logic        mem_init;
  logic [7:0]  exp_s [256];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [23:0] key;
    int          widx;
    logic [7:0]  addr;
    logic [7:0]  data;
  } wr_vec_t;

  wr_t     wlog[$];
  wr_vec_t vecs[10];

  int total = 0;
  int bad   = 0;

  shuffle_mem #(.KEY_BYTES(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .secret_key (secret_key),
    .address    (address),
    .data       (data),
    .wen        (wen),
    .q          (q),
    .finished   (finished)
  );

  always #5 clk = ~clk;

  // S memory with two-cycle read latency
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (wen) begin
      mem[address] <= data;
    end
    rd1 <= mem[address];
    q   <= rd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic ksa_model(input logic [23:0] key);
    logic [7:0] kb [3];
    logic [7:0] j;
    logic [7:0] t;
    kb[0] = key[23:16];
    kb[1] = key[15:8];
    kb[2] = key[7:0];
    for (int k = 0; k < 256; k++) exp_s[k] = 8'(k);
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      j        = j + exp_s[i] + kb[i % 3];
      t        = exp_s[i];
      exp_s[i] = exp_s[j];
      exp_s[j] = t;
    end
  endtask

  task automatic load_identity();
    @(negedge clk);
    mem_init = 1'b1;
    @(negedge clk);
    mem_init = 1'b0;
  endtask

  task automatic run_pass(input string tag, input logic [23:0] key,
                          input bit hold_start, input bit swap_key);
    int fin_cnt;
    int fin_cyc;
    int late_wen;
    int bad_bytes;
    fin_cnt   = 0;
    fin_cyc   = 0;
    late_wen  = 0;
    bad_bytes = 0;
    wlog.delete();
    load_identity();
    secret_key = key;
    start      = 1'b1;
    for (int cyc = 1; cyc <= 2060; cyc++) begin
      @(negedge clk);
      if (!hold_start || cyc >= 2050) start = 1'b0;
      if (swap_key && cyc == 10) secret_key = ~key;
      if (finished) begin
        fin_cnt++;
        fin_cyc = cyc;
      end
      if (wen) begin
        if (cyc > 2049) late_wen++;
        wlog.push_back('{address, data});
      end
    end
    ksa_model(key);
    for (int k = 0; k < 256; k++) begin
      if (mem[k] !== exp_s[k]) bad_bytes++;
    end
    check({tag, " finished_count"}, fin_cnt, 1);
    check({tag, " finished_cycle"}, fin_cyc, 2049);
    check({tag, " write_count"}, wlog.size(), 512);
    check({tag, " late_writes"}, late_wen, 0);
    check({tag, " S_bytes_wrong"}, bad_bytes, 0);
  endtask

  task automatic check_vectors(input string tag, input logic [23:0] key);
    for (int v = 0; v < 10; v++) begin
      if (vecs[v].key == key) begin
        if (vecs[v].widx < wlog.size()) begin
          check($sformatf("%s wr%0d_addr", tag, vecs[v].widx), wlog[vecs[v].widx].addr, vecs[v].addr);
          check($sformatf("%s wr%0d_data", tag, vecs[v].widx), wlog[vecs[v].widx].data, vecs[v].data);
        end else begin
          check($sformatf("%s wr%0d_present", tag, vecs[v].widx), wlog.size(), vecs[v].widx + 1);
        end
      end
    end
  endtask

  initial begin
    int fin_cnt;
    int wen_cnt;

    // Expected write sequences, derived by hand from the KSA recurrence
    vecs[0] = '{24'h010203, 0, 8'd0, 8'd1};
    vecs[1] = '{24'h010203, 1, 8'd1, 8'd0};
    vecs[2] = '{24'h010203, 2, 8'd1, 8'd3};
    vecs[3] = '{24'h010203, 3, 8'd3, 8'd0};
    vecs[4] = '{24'h000000, 0, 8'd0, 8'd0};
    vecs[5] = '{24'h000000, 1, 8'd0, 8'd0};
    vecs[6] = '{24'h000000, 2, 8'd1, 8'd1};
    vecs[7] = '{24'h000000, 3, 8'd1, 8'd1};
    vecs[8] = '{24'h000000, 4, 8'd2, 8'd3};
    vecs[9] = '{24'h000000, 5, 8'd3, 8'd2};

    reset      = 1'b1;
    start      = 1'b0;
    secret_key = 24'h0;
    mem_init   = 1'b0;
    #1;
    check("reset address", address, 0);
    check("reset data", data, 0);
    check("reset wen", wen, 0);
    check("reset finished", finished, 0);
    check("reset state", 32'(dut.state_q), 32'(IDLE));
    repeat (3) @(negedge clk);
    reset = 1'b0;

    run_pass("key010203", 24'h010203, 1'b0, 1'b0);
    check_vectors("key010203", 24'h010203);

    run_pass("key000000", 24'h000000, 1'b0, 1'b0);
    check_vectors("key000000", 24'h000000);

    run_pass("start_held", 24'h0A0B0C, 1'b1, 1'b0);

    // Abort during WR_I of iteration 100 (cycle 100*8+7)
    load_identity();
    secret_key = 24'h5A3C11;
    start      = 1'b1;
    for (int cyc = 1; cyc <= 807; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("abort pre wen", wen, 1);
    check("abort pre address", address, 100);
    check("abort pre state", 32'(dut.state_q), 32'(WR_I));
    #1;
    reset = 1'b1;
    #1;
    check("abort wen", wen, 0);
    check("abort address", address, 0);
    check("abort data", data, 0);
    check("abort finished", finished, 0);
    check("abort state", 32'(dut.state_q), 32'(IDLE));
    check("abort i", dut.i_q, 0);
    check("abort j", dut.j_q, 0);
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    fin_cnt = 0;
    wen_cnt = 0;
    for (int cyc = 0; cyc < 2100; cyc++) begin
      @(negedge clk);
      if (finished) fin_cnt++;
      if (wen) wen_cnt++;
    end
    check("abort no_finished", fin_cnt, 0);
    check("abort no_resume", wen_cnt, 0);

    run_pass("after_abort", 24'h5A3C11, 1'b0, 1'b0);

`ifdef SHUFFLE_KEY_LATCH_EN
    run_pass("key_latch", 24'h0A0B0C, 1'b0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
